clock_core_param: RTL and testbench

- Parametrised successor to the team's 1 Hz time-of-day counter; keeps seconds/minutes/hours with a configurable day length.
- Adds run/pause, validated synchronous load, per-field adjust, 12/24 h display, and a day-rollover pulse that feeds the calendar block.
- Sits between the 1 Hz tick domain and the BCD display/LED drivers.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/clock_if.sv | 37 +++
 rtl/bin2bcd2.sv | 10 +
 rtl/clock_core_param.sv | 160 ++++++++++++++++
 tb/tb_clock_core_param.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types and helpers for the time-of-day core: field widths, packed time struct, load validation.
// The hour field is sized for DAY_HOURS up to 99, so HOUR_W above 7 is not supported.
`timescale 1ns/1ps
package clock_pkg;
   localparam int SEC_W      = 6;
   localparam int MIN_W      = 6;
   localparam int HOUR_MAX_W = 7;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   typedef struct packed {
      logic [HOUR_MAX_W-1:0] hour;
      logic [MIN_W-1:0]      min;
      logic [SEC_W-1:0]      sec;
   } clock_time_t;

   function automatic logic time_valid(input clock_time_t t, input logic [HOUR_MAX_W-1:0] day_hours);
      return (t.sec <= SEC_MAX) && (t.min <= MIN_MAX) && (t.hour < day_hours);
   endfunction
endpackage

// File: rtl/clock_if.sv
// Control/status bundle between the tick-domain controller (master) and the clock core (slave).
`timescale 1ns/1ps
interface clock_if
   import clock_pkg::*;
#(
   parameter int HOUR_W = 5
) ();
   logic                  run;
   logic                  time_ow;
   logic [HOUR_W+11:0]    time_in;
   logic                  adj_hr;
   logic                  adj_min;
   logic                  mode_12h;
   logic [HOUR_W-1:0]     hour_out;
   logic [MIN_W-1:0]      min_out;
   logic [SEC_W-1:0]      sec_out;
   logic [3:0]            sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
   logic                  pm;
   logic                  day_tick;
   logic                  load_err;
   logic                  alarm_set;
   logic                  alarm_arm;
   logic [HOUR_W+11:0]    alarm_in;
   logic                  alarm_hit;

   modport master (
      output run, time_ow, time_in, adj_hr, adj_min, mode_12h, alarm_set, alarm_arm, alarm_in,
      input  hour_out, min_out, sec_out, sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s,
             pm, day_tick, load_err, alarm_hit
   );

   modport slave (
      input  run, time_ow, time_in, adj_hr, adj_min, mode_12h, alarm_set, alarm_arm, alarm_in,
      output hour_out, min_out, sec_out, sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s,
             pm, day_tick, load_err, alarm_hit
   );
endinterface

// File: rtl/bin2bcd2.sv
// Combinational binary (0..99) to two BCD digits.
`timescale 1ns/1ps
module bin2bcd2 (
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);
   assign tens = 4'(bin / 7'd10);
   assign ones = 4'(bin % 7'd10);
endmodule

// File: rtl/clock_core_param.sv
// Parametrised time-of-day counter on the 1 Hz clock with load, adjust, 12/24 h display and rollover pulse.
// Optional alarm compare is built when CLOCK_ALARM_EN is defined; otherwise alarm inputs are ignored.
`timescale 1ns/1ps
module clock_core_param
   import clock_pkg::*;
#(
   parameter int HOUR_W     = 5,
   parameter int DAY_HOURS  = 24,
   parameter int RESET_HOUR = 0
) (
   input  logic   clk_1hz,
   input  logic   rst,
   clock_if.slave bus
);
   localparam logic [HOUR_W-1:0]     HOUR_LAST = HOUR_W'(DAY_HOURS - 1);
   localparam logic [HOUR_W-1:0]     HOUR_RST  = HOUR_W'(RESET_HOUR);
   localparam logic [HOUR_MAX_W-1:0] DAY_LEN   = HOUR_MAX_W'(DAY_HOURS);

   logic [SEC_W-1:0]  sec_reg, sec_next;
   logic [MIN_W-1:0]  min_reg, min_next, min_inc;
   logic [HOUR_W-1:0] hour_reg, hour_next, hour_inc;
   logic              day_tick_reg, load_err_reg, alarm_hit_reg;
   logic              sec_wrap, min_wrap, hour_wrap, rollover_next;
   logic              load_ok, alarm_match, alarm_err;
   clock_time_t       load_t;

   always_comb begin
      sec_wrap      = (sec_reg == SEC_MAX);
      min_wrap      = (min_reg == MIN_MAX);
      hour_wrap     = (hour_reg == HOUR_LAST);
      min_inc       = min_wrap ? '0 : min_reg + MIN_W'(1);
      hour_inc      = hour_wrap ? '0 : hour_reg + HOUR_W'(1);
      sec_next      = sec_wrap ? '0 : sec_reg + SEC_W'(1);
      min_next      = sec_wrap ? min_inc : min_reg;
      hour_next     = (sec_wrap && min_wrap) ? hour_inc : hour_reg;
      rollover_next = sec_wrap && min_wrap && hour_wrap;
   end

   assign load_t  = '{hour: HOUR_MAX_W'(bus.time_in[HOUR_W+11:12]),
                      min:  bus.time_in[11:6],
                      sec:  bus.time_in[5:0]};
   assign load_ok = time_valid(load_t, DAY_LEN);

`ifdef CLOCK_ALARM_EN
   clock_time_t alarm_reg, alarm_t, count_t;
   logic        alarm_ok;

   assign alarm_t  = '{hour: HOUR_MAX_W'(bus.alarm_in[HOUR_W+11:12]),
                       min:  bus.alarm_in[11:6],
                       sec:  bus.alarm_in[5:0]};
   assign alarm_ok = time_valid(alarm_t, DAY_LEN);
   assign count_t  = '{hour: HOUR_MAX_W'(hour_next), min: min_next, sec: sec_next};
   // Compared against the count result only, so loads and adjusts never fire the alarm.
   assign alarm_match = bus.alarm_arm && (count_t == alarm_reg);
   assign alarm_err   = bus.alarm_set && !alarm_ok;

   always_ff @(posedge clk_1hz) begin
      if (rst) begin
         alarm_reg <= '0;
      end else if (bus.alarm_set && alarm_ok) begin
         alarm_reg <= alarm_t;
      end
   end
`else
   logic alarm_unused;
   assign alarm_unused = ^{bus.alarm_set, bus.alarm_arm, bus.alarm_in};
   assign alarm_match  = 1'b0;
   assign alarm_err    = 1'b0;
`endif

   always_ff @(posedge clk_1hz) begin
      if (rst) begin
         sec_reg       <= '0;
         min_reg       <= '0;
         hour_reg      <= HOUR_RST;
         day_tick_reg  <= 1'b0;
         load_err_reg  <= 1'b0;
         alarm_hit_reg <= 1'b0;
      end else begin
         day_tick_reg  <= 1'b0;
         load_err_reg  <= alarm_err;
         alarm_hit_reg <= 1'b0;
         if (bus.time_ow) begin
            if (load_ok) begin
               sec_reg  <= load_t.sec;
               min_reg  <= load_t.min;
               hour_reg <= HOUR_W'(load_t.hour);
            end else begin
               load_err_reg <= 1'b1;
            end
         end else if (bus.adj_hr || bus.adj_min) begin
            if (bus.adj_min) min_reg  <= min_inc;
            if (bus.adj_hr)  hour_reg <= hour_inc;
         end else if (bus.run) begin
            sec_reg       <= sec_next;
            min_reg       <= min_next;
            hour_reg      <= hour_next;
            day_tick_reg  <= rollover_next;
            alarm_hit_reg <= alarm_match;
         end
      end
   end

   logic [6:0] hr_disp;
   logic       pm_disp;

   generate
      if (DAY_HOURS == 24) begin : g_12h
         always_comb begin
            hr_disp = 7'(hour_reg);
            pm_disp = 1'b0;
            if (bus.mode_12h) begin
               pm_disp = (hour_reg >= HOUR_W'(12));
               if (hour_reg == '0)
                  hr_disp = 7'd12;
               else if (hour_reg > HOUR_W'(12))
                  hr_disp = 7'(hour_reg - HOUR_W'(12));
            end
         end
      end else begin : g_24h
         logic mode_unused;
         assign mode_unused = bus.mode_12h;
         assign hr_disp     = 7'(hour_reg);
         assign pm_disp     = 1'b0;
      end
   endgenerate

   // Digit pairs: 0 = seconds, 1 = minutes, 2 = display hour.
   logic [6:0] bcd_bin  [3];
   logic [3:0] bcd_tens [3];
   logic [3:0] bcd_ones [3];

   assign bcd_bin[0] = 7'(sec_reg);
   assign bcd_bin[1] = 7'(min_reg);
   assign bcd_bin[2] = hr_disp;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
         bin2bcd2 u_bcd (
            .bin  (bcd_bin[gi]),
            .tens (bcd_tens[gi]),
            .ones (bcd_ones[gi])
         );
      end
   endgenerate

   assign bus.sec_out   = sec_reg;
   assign bus.min_out   = min_reg;
   assign bus.hour_out  = hour_reg;
   assign bus.sec_1s    = bcd_ones[0];
   assign bus.sec_10s   = bcd_tens[0];
   assign bus.min_1s    = bcd_ones[1];
   assign bus.min_10s   = bcd_tens[1];
   assign bus.hr_1s     = bcd_ones[2];
   assign bus.hr_10s    = bcd_tens[2];
   assign bus.pm        = pm_disp;
   assign bus.day_tick  = day_tick_reg;
   assign bus.load_err  = load_err_reg;
   assign bus.alarm_hit = alarm_hit_reg;
endmodule

// File: tb/tb_clock_core_param.sv
// Directed bench for clock_core_param: 24 h instance plus a 12 h-day instance, scoreboard-checked.
`timescale 1ns/1ps
module tb_clock_core_param;
   logic clk_1hz = 1'b0;
   logic rst;

   clock_if #(.HOUR_W(5)) a_if ();
   clock_if #(.HOUR_W(4)) b_if ();

   clock_core_param #(.HOUR_W(5), .DAY_HOURS(24), .RESET_HOUR(0)) dut_a (
      .clk_1hz (clk_1hz),
      .rst     (rst),
      .bus     (a_if.slave)
   );

   clock_core_param #(.HOUR_W(4), .DAY_HOURS(12), .RESET_HOUR(3)) dut_b (
      .clk_1hz (clk_1hz),
      .rst     (rst),
      .bus     (b_if.slave)
   );

   always #5 clk_1hz = ~clk_1hz;

`ifdef CLOCK_ALARM_EN
   localparam logic ALARM = 1'b1;
`else
   localparam logic ALARM = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic [31:0] value;
   } sb_t;

   sb_t sb_q[$];
   int  passed = 0;
   int  total  = 0;

   task automatic push(input string tag, input logic [31:0] v);
      sb_q.push_back('{tag, v});
   endtask

   task automatic pop_check(input logic [31:0] obs);
      sb_t e;
      total++;
      if (sb_q.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0d expected <none>", obs);
         return;
      end
      e = sb_q.pop_front();
      assert (obs === e.value) passed++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.value);
   endtask

   task automatic tick();
      @(posedge clk_1hz);
      #1;
   endtask

   task automatic exp_a(input int h, input int m, input int s, input int dt, input int le, input int hit);
      push("a_hour", 32'(h)); push("a_min", 32'(m)); push("a_sec", 32'(s));
      push("a_day_tick", 32'(dt)); push("a_load_err", 32'(le)); push("a_alarm_hit", 32'(hit));
   endtask

   task automatic chk_a();
      pop_check(32'(a_if.hour_out)); pop_check(32'(a_if.min_out)); pop_check(32'(a_if.sec_out));
      pop_check(32'(a_if.day_tick)); pop_check(32'(a_if.load_err)); pop_check(32'(a_if.alarm_hit));
      $display("step t=%0t a=%0d:%0d:%0d dt=%0d le=%0d hit=%0d", $time, a_if.hour_out, a_if.min_out,
               a_if.sec_out, a_if.day_tick, a_if.load_err, a_if.alarm_hit);
   endtask

   task automatic exp_b(input int h, input int m, input int s, input int dt, input int le);
      push("b_hour", 32'(h)); push("b_min", 32'(m)); push("b_sec", 32'(s));
      push("b_day_tick", 32'(dt)); push("b_load_err", 32'(le));
   endtask

   task automatic chk_b();
      pop_check(32'(b_if.hour_out)); pop_check(32'(b_if.min_out)); pop_check(32'(b_if.sec_out));
      pop_check(32'(b_if.day_tick)); pop_check(32'(b_if.load_err));
      $display("step t=%0t b=%0d:%0d:%0d dt=%0d le=%0d", $time, b_if.hour_out, b_if.min_out,
               b_if.sec_out, b_if.day_tick, b_if.load_err);
   endtask

   task automatic exp_disp(input int h10, input int h1, input int pm);
      push("hr_10s", 32'(h10)); push("hr_1s", 32'(h1)); push("pm", 32'(pm));
   endtask

   task automatic chk_disp_a();
      pop_check(32'(a_if.hr_10s)); pop_check(32'(a_if.hr_1s)); pop_check(32'(a_if.pm));
   endtask

   task automatic chk_disp_b();
      pop_check(32'(b_if.hr_10s)); pop_check(32'(b_if.hr_1s)); pop_check(32'(b_if.pm));
   endtask

   task automatic exp_ms(input int m10, input int m1, input int s10, input int s1);
      push("min_10s", 32'(m10)); push("min_1s", 32'(m1));
      push("sec_10s", 32'(s10)); push("sec_1s", 32'(s1));
   endtask

   task automatic chk_ms_a();
      pop_check(32'(a_if.min_10s)); pop_check(32'(a_if.min_1s));
      pop_check(32'(a_if.sec_10s)); pop_check(32'(a_if.sec_1s));
   endtask

   task automatic set_a_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      a_if.time_in = {h, m, s};
   endtask

   int hrs_12  [3] = '{0, 12, 13};
   int tens_12 [3] = '{1, 1, 0};
   int ones_12 [3] = '{2, 2, 1};
   int pm_12   [3] = '{0, 1, 1};

   initial begin
      rst = 1'b1;
      a_if.run = 0; a_if.time_ow = 0; a_if.time_in = '0; a_if.adj_hr = 0; a_if.adj_min = 0;
      a_if.mode_12h = 0; a_if.alarm_set = 0; a_if.alarm_arm = 0; a_if.alarm_in = '0;
      b_if.run = 0; b_if.time_ow = 0; b_if.time_in = '0; b_if.adj_hr = 0; b_if.adj_min = 0;
      b_if.mode_12h = 0; b_if.alarm_set = 0; b_if.alarm_arm = 0; b_if.alarm_in = '0;

      // Reset values
      exp_a(0, 0, 0, 0, 0, 0); exp_b(3, 0, 0, 0, 0);
      tick(); chk_a(); chk_b();
      rst = 1'b0;

      // Day rollover
      set_a_time(5'd23, 6'd59, 6'd58); a_if.time_ow = 1; a_if.run = 1;
      exp_a(23, 59, 58, 0, 0, 0); tick(); chk_a();
      a_if.time_ow = 0;
      exp_a(23, 59, 59, 0, 0, 0); tick(); chk_a();
      a_if.mode_12h = 1;
      exp_a(0, 0, 0, 1, 0, 0); exp_disp(1, 2, 0); tick(); chk_a(); chk_disp_a();
      a_if.run = 0;
      exp_a(0, 0, 0, 0, 0, 0); tick(); chk_a();

      // Invalid load, then a valid one with digit checks
      set_a_time(5'd10, 6'd60, 6'd0); a_if.time_ow = 1;
      exp_a(0, 0, 0, 0, 1, 0); tick(); chk_a();
      a_if.time_ow = 0;
      exp_a(0, 0, 0, 0, 0, 0); tick(); chk_a();
      a_if.mode_12h = 0;
      set_a_time(5'd10, 6'd30, 6'd15); a_if.time_ow = 1;
      exp_a(10, 30, 15, 0, 0, 0); exp_disp(1, 0, 0); exp_ms(3, 0, 1, 5);
      tick(); chk_a(); chk_disp_a(); chk_ms_a();

      // Adjust both fields, no carry, no count
      set_a_time(5'd22, 6'd59, 6'd40);
      exp_a(22, 59, 40, 0, 0, 0); tick(); chk_a();
      a_if.time_ow = 0; a_if.run = 1; a_if.adj_hr = 1; a_if.adj_min = 1;
      exp_a(23, 0, 40, 0, 0, 0); tick(); chk_a();
      a_if.adj_hr = 0; a_if.adj_min = 0;
      exp_a(23, 0, 41, 0, 0, 0); tick(); chk_a();

      // Pause
      a_if.run = 0;
      for (int i = 0; i < 5; i++) begin
         exp_a(23, 0, 41, 0, 0, 0); tick(); chk_a();
      end

      // Hour adjust wraps without day_tick; minute adjust wraps without carry
      a_if.adj_hr = 1;
      exp_a(0, 0, 41, 0, 0, 0); tick(); chk_a();
      a_if.adj_hr = 0;
      set_a_time(5'd5, 6'd59, 6'd30); a_if.time_ow = 1;
      exp_a(5, 59, 30, 0, 0, 0); tick(); chk_a();
      a_if.time_ow = 0; a_if.adj_min = 1;
      exp_a(5, 0, 30, 0, 0, 0); tick(); chk_a();
      a_if.adj_min = 0;

      // Reset wins over an invalid load
      set_a_time(5'd10, 6'd60, 6'd0); a_if.time_ow = 1; rst = 1;
      exp_a(0, 0, 0, 0, 0, 0); exp_b(3, 0, 0, 0, 0); tick(); chk_a(); chk_b();
      rst = 0; a_if.time_ow = 0;

      // 12 h display mapping
      a_if.mode_12h = 1; a_if.time_ow = 1;
      for (int i = 0; i < 3; i++) begin
         set_a_time(5'(hrs_12[i]), 6'd0, 6'd0);
         exp_a(hrs_12[i], 0, 0, 0, 0, 0); exp_disp(tens_12[i], ones_12[i], pm_12[i]);
         tick(); chk_a(); chk_disp_a();
      end
      a_if.time_ow = 0; a_if.mode_12h = 0;

      // 12-hour day: mode ignored, wrap 11 -> 0
      b_if.mode_12h = 1; b_if.time_in = {4'd11, 6'd59, 6'd59}; b_if.time_ow = 1;
      exp_b(11, 59, 59, 0, 0); exp_disp(1, 1, 0); tick(); chk_b(); chk_disp_b();
      b_if.time_ow = 0; b_if.run = 1;
      exp_b(0, 0, 0, 1, 0); exp_disp(0, 0, 0); tick(); chk_b(); chk_disp_b();
      b_if.run = 0; b_if.time_in = {4'd12, 6'd0, 6'd0}; b_if.time_ow = 1;
      exp_b(0, 0, 0, 0, 1); tick(); chk_b();
      b_if.time_ow = 0;

      // Alarm (expected hits only when the feature is built in)
      a_if.alarm_in = {5'd7, 6'd0, 6'd0}; a_if.alarm_set = 1; a_if.alarm_arm = 1;
      set_a_time(5'd6, 6'd59, 6'd59); a_if.time_ow = 1;
      exp_a(6, 59, 59, 0, 0, 0); tick(); chk_a();
      a_if.alarm_set = 0; a_if.time_ow = 0; a_if.run = 1;
      exp_a(7, 0, 0, 0, 0, 32'(ALARM)); tick(); chk_a();
      exp_a(7, 0, 1, 0, 0, 0); tick(); chk_a();
      a_if.run = 0; a_if.alarm_arm = 0; set_a_time(5'd6, 6'd59, 6'd59); a_if.time_ow = 1;
      exp_a(6, 59, 59, 0, 0, 0); tick(); chk_a();
      a_if.time_ow = 0; a_if.run = 1;
      exp_a(7, 0, 0, 0, 0, 0); tick(); chk_a();
      a_if.run = 0; a_if.alarm_arm = 1; set_a_time(5'd7, 6'd0, 6'd0); a_if.time_ow = 1;
      exp_a(7, 0, 0, 0, 0, 0); tick(); chk_a();
      set_a_time(5'd6, 6'd0, 6'd0);
      exp_a(6, 0, 0, 0, 0, 0); tick(); chk_a();
      a_if.time_ow = 0; a_if.adj_hr = 1;
      exp_a(7, 0, 0, 0, 0, 0); tick(); chk_a();
      a_if.adj_hr = 0;

      // Invalid alarm value is rejected and the stored alarm survives
      a_if.alarm_in = {5'd7, 6'd60, 6'd0}; a_if.alarm_set = 1;
      exp_a(7, 0, 0, 0, 32'(ALARM), 0); tick(); chk_a();
      a_if.alarm_set = 0; set_a_time(5'd6, 6'd59, 6'd59); a_if.time_ow = 1;
      exp_a(6, 59, 59, 0, 0, 0); tick(); chk_a();
      a_if.time_ow = 0; a_if.run = 1;
      exp_a(7, 0, 0, 0, 0, 32'(ALARM)); tick(); chk_a();
      a_if.run = 0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
